counter_burst_sched: RTL and testbench

- Sequencing controller for the team's 4-bit enable-gated counter (`first_counter`).
- Two requesters share the counter. Each asks for a burst of `len` counts.
- The block runs each burst in order: round-robin arbitration, one clear cycle, then `len` cycles of `enable`. Completion is read back from `counter_out`.
- Sits between requester logic and the counter instance, and drives that counter's `reset` and `enable` pins.

---
 rtl/counter_burst_sched.sv | 132 +++++++++++++
 tb/tb_counter_burst_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_burst_sched.sv
// Round-robin burst sequencer in front of a 4-bit enable-gated counter: clear, count len, report done.
// Optional RUN watchdog enabled by defining COUNTER_BURST_SCHED_WATCHDOG_EN.
module counter_burst_sched #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] count_in,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic             err,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // The watchdog counter is 5 bits, so TIMEOUT must fit it and outlast a full count.
    if (TIMEOUT < (1 << WIDTH) || TIMEOUT > 32) begin : g_bad_timeout
        $error("counter_burst_sched: TIMEOUT out of range");
    end

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             last_q, last_d;   // 1 = requester 1 was granted most recently
    logic             pick;
    logic             hit;

    // Handshake: req is a level; a grant is taken only in IDLE and gnt stays
    // one-hot from CLEAR through DONE, where done pulses once on the same bit.
    assign pick = req[1] && (!req[0] || !last_q);
    assign hit  = (count_in == (len_q - ONE));

`ifdef COUNTER_BURST_SCHED_WATCHDOG_EN
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);
    logic [4:0] run_cnt_q;
    logic       err_q;
    logic       timeout_hit;

    assign timeout_hit = (state_q == RUN) && !hit && (run_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == CLEAR)
                run_cnt_q <= '0;
            else if (state_q == RUN)
                run_cnt_q <= run_cnt_q + 5'd1;
            err_q <= timeout_hit;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    len_d   = pick ? len1 : len0;
                    last_d  = pick;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = (len_q != '0) ? RUN : DONE;
            RUN: begin
                if (hit)
                    state_d = DONE;
`ifdef COUNTER_BURST_SCHED_WATCHDOG_EN
                else if (timeout_hit)
                    state_d = DONE;
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt        = gnt_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE) ? gnt_q : 2'b00;
        cnt_reset  = (state_q == CLEAR);
        cnt_enable = (state_q == RUN);
        dbg_state  = state_q;
`ifdef COUNTER_BURST_SCHED_WATCHDOG_EN
        err        = err_q;
`else
        err        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_counter_burst_sched.sv
// Directed bench for counter_burst_sched with a behavioural model of the 4-bit counter it drives.
module tb_counter_burst_sched;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [3:0] len0  = 4'd0;
    logic [3:0] len1  = 4'd0;
    logic [3:0] count_in;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic       err;
    logic       cnt_reset;
    logic       cnt_enable;
    logic [1:0] dbg_state;

    logic [3:0] cnt   = 4'd0;
    logic       stuck = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    // Counter model: synchronous active-high clear, enable-gated increment, untouched by reset.
    always @(posedge clock) begin
        if (cnt_reset)
            cnt <= 4'd0;
        else if (cnt_enable)
            cnt <= cnt + 4'd1;
    end
    assign count_in = stuck ? 4'd0 : cnt;

    counter_burst_sched #(.WIDTH(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .req(req), .len0(len0), .len1(len1),
        .count_in(count_in), .gnt(gnt), .busy(busy), .done(done), .err(err),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until done pulses or the budget runs out; edges counts from the first edge taken.
    task automatic wait_done(input int budget, output int edges, output int en_cyc,
                             output int clr_cyc, output logic [1:0] done_v,
                             output logic err_v, output logic [3:0] cnt_v);
        edges = 0; en_cyc = 0; clr_cyc = 0; done_v = 2'b00; err_v = 1'b0; cnt_v = 4'd0;
        while (edges < budget) begin
            step();
            edges++;
            if (cnt_enable) en_cyc++;
            if (cnt_reset) clr_cyc++;
            if (done !== 2'b00) begin
                done_v = done; err_v = err; cnt_v = cnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        checks++;
        if ({gnt, busy, done, err, cnt_reset, cnt_enable, dbg_state} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {gnt, busy, done, err, cnt_reset, cnt_enable, dbg_state});
        end
        reset = 1'b1;
        step();
        checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: state %0d busy %b expected 0/0", dbg_state, busy);
        end
    endtask

    task automatic test_single();
        int e, en, clr; logic [1:0] d; logic er; logic [3:0] c;
        req = 2'b01; len0 = 4'd5;
        step();
        checks++;
        if (gnt !== 2'b01 || cnt_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt %b rst %b busy %b expected 01/1/1", gnt, cnt_reset, busy);
        end
        req = 2'b00; len0 = 4'd9;
        wait_done(30, e, en, clr, d, er, c);
        checks++;
        if (e + 1 !== 7 || d !== 2'b01) begin
            errors++;
            $display("FAIL single_done: edge %0d done %b expected 7/01", e + 1, d);
        end
        checks++;
        if (en !== 5 || clr !== 0 || c !== 4'd5 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL single_counts: en %0d clr %0d cnt %0d gnt %b expected 5/0/5/01", en, clr, c, gnt);
        end
        step();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
            errors++;
            $display("FAIL single_release: gnt %b busy %b done %b expected 00/0/00", gnt, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int e, en, clr; logic [1:0] d; logic er; logic [3:0] c;
        reset = 1'b0; #1; reset = 1'b1;
        req = 2'b11; len0 = 4'd3; len1 = 4'd4;
        wait_done(30, e, en, clr, d, er, c);
        checks++;
        if (e !== 5 || d !== 2'b01 || c !== 4'd3) begin
            errors++;
            $display("FAIL b2b_first: edge %0d done %b cnt %0d expected 5/01/3", e, d, c);
        end
        step();
        checks++;
        if (dbg_state !== 2'd0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: state %0d gnt %b expected 0/00", dbg_state, gnt);
        end
        wait_done(30, e, en, clr, d, er, c);
        checks++;
        if (e !== 6 || d !== 2'b10 || c !== 4'd4 || en !== 4) begin
            errors++;
            $display("FAIL b2b_second: edge %0d done %b cnt %0d en %0d expected 6/10/4/4", e, d, c, en);
        end
        step();
        step();
        checks++;
        if (gnt !== 2'b01 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL b2b_third_grant: gnt %b state %0d expected 01/1", gnt, dbg_state);
        end
        req = 2'b00;
        wait_done(30, e, en, clr, d, er, c);
        checks++;
        if (e !== 4 || d !== 2'b01 || c !== 4'd3) begin
            errors++;
            $display("FAIL b2b_third_done: edge %0d done %b cnt %0d expected 4/01/3", e, d, c);
        end
        step();
    endtask

    task automatic test_zero_len();
        int e, en, clr; logic [1:0] d; logic er; logic [3:0] c;
        req = 2'b10; len1 = 4'd0;
        wait_done(30, e, en, clr, d, er, c);
        checks++;
        if (e !== 2 || d !== 2'b10 || en !== 0 || clr !== 1) begin
            errors++;
            $display("FAIL zero_len: edge %0d done %b en %0d clr %0d expected 2/10/0/1", e, d, en, clr);
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_max_len();
        int e, en, clr; logic [1:0] d; logic er; logic [3:0] c;
        req = 2'b01; len0 = 4'd15;
        wait_done(40, e, en, clr, d, er, c);
        checks++;
        if (e !== 17 || d !== 2'b01 || en !== 15 || c !== 4'd15) begin
            errors++;
            $display("FAIL max_len: edge %0d done %b en %0d cnt %0d expected 17/01/15/15", e, d, en, c);
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        req = 2'b01; len0 = 4'd8; len1 = 4'd2;
        step(); step(); step();
        checks++;
        if (dbg_state !== 2'd2 || cnt_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_run: state %0d en %b expected 2/1", dbg_state, cnt_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, done, err, cnt_reset, cnt_enable, dbg_state} !== 10'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got %b expected 0", {gnt, busy, done, err, cnt_reset, cnt_enable, dbg_state});
        end
        req = 2'b11;
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL mid_pointer: gnt %b expected 01", gnt);
        end
        req = 2'b00;
        step();
        checks++;
        if (cnt !== 4'd0 || cnt_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_reclear: cnt %0d en %b expected 0/1", cnt, cnt_enable);
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_watchdog();
        stuck = 1'b1;
        req = 2'b01; len0 = 4'd6;
`ifdef COUNTER_BURST_SCHED_WATCHDOG_EN
        begin
            int e, en, clr; logic [1:0] d; logic er; logic [3:0] c;
            wait_done(40, e, en, clr, d, er, c);
            checks++;
            if (e !== 18 || en !== 16 || d !== 2'b01 || er !== 1'b1) begin
                errors++;
                $display("FAIL watchdog_abort: edge %0d en %0d done %b err %b expected 18/16/01/1", e, en, d, er);
            end
            req = 2'b00;
            step();
            checks++;
            if (err !== 1'b0 || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL watchdog_clear: err %b state %0d expected 0/0", err, dbg_state);
            end
        end
`else
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 25; i++) begin
                step();
                if (done !== 2'b00 || err !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0 || dbg_state !== 2'd2 || cnt_enable !== 1'b1) begin
                errors++;
                $display("FAIL stuck_run: seen %b state %0d en %b expected 0/2/1", seen, dbg_state, cnt_enable);
            end
            req = 2'b00;
            reset = 1'b0;
            #1;
            reset = 1'b1;
            step();
        end
`endif
        stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_max_len();
        test_reset_mid();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
